// File: rtl/seg7_capture.sv
// Sequential 7-segment decoder: samples a multiplexed active-low display bus, filters
// each digit for stability, decodes it to a nibble and presents 16-bit frames on valid/ready.
module seg7_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  dig_sel,
    input  logic        out_ready,
    output logic [15:0] out_word,
    output logic [3:0]  out_err,
    output logic        out_valid,
    output logic        overrun
);

    localparam logic [6:0] Blank = 7'h7F;
    // One bit wider than eight so STABLE_CYCLES = 255 can still saturate above the capture point.
    localparam logic [8:0] CntCapture = 9'(STABLE_CYCLES);
    localparam logic [8:0] CntSat     = 9'(STABLE_CYCLES + 1);

    logic [6:0]  s_seg_q;
    logic [3:0]  s_sel_q;
    logic [8:0]  cnt_q, cnt_d;
    logic [15:0] slot_q, slot_d;
    logic [3:0]  slot_err_q, slot_err_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] word_q, word_d;
    logic [3:0]  err_q, err_d;
    logic        valid_q, valid_d;
    logic        ovr_q, ovr_d;

    logic        sample_change;
    logic        sel_onehot;
    logic        capture;
    logic        accept;
    logic        frame_done;
    logic [3:0]  dec_nib;
    logic        dec_ill;

    // Returns {illegal, nibble}; illegal patterns decode to nibble 0.
    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h40:   r = 5'h00;
            7'h79:   r = 5'h01;
            7'h24:   r = 5'h02;
            7'h30:   r = 5'h03;
            7'h19:   r = 5'h04;
            7'h12:   r = 5'h05;
            7'h02:   r = 5'h06;
            7'h78:   r = 5'h07;
            7'h00:   r = 5'h08;
            7'h10:   r = 5'h09;
            7'h08:   r = 5'h0A;
            7'h03:   r = 5'h0B;
            7'h46:   r = 5'h0C;
            7'h21:   r = 5'h0D;
            7'h06:   r = 5'h0E;
            7'h0E:   r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

    always_comb begin
        sample_change = (seg != s_seg_q) || (dig_sel != s_sel_q);
        if (sample_change) begin
            cnt_d = 9'd1;
        end else if (cnt_q == CntSat) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 9'd1;
        end
    end

    always_comb begin
        sel_onehot = (s_sel_q != 4'h0) && ((s_sel_q & (s_sel_q - 4'd1)) == 4'h0);
        // Equality (not >=) gives exactly one capture per stable run.
        capture    = (cnt_q == CntCapture) && sel_onehot && (s_seg_q != Blank);
        accept     = valid_q && out_ready;
        {dec_ill, dec_nib} = decode(s_seg_q);
    end

    always_comb begin
        slot_d     = slot_q;
        slot_err_d = slot_err_q;
        mask_d     = mask_q;
        word_d     = word_q;
        err_d      = err_q;
        valid_d    = valid_q;
        ovr_d      = ovr_q;
        frame_done = 1'b0;

        if (capture) begin
            for (int i = 0; i < 4; i++) begin
                if (s_sel_q[i]) begin
                    slot_d[4*i +: 4] = dec_nib;
                    slot_err_d[i]    = dec_ill;
                end
            end
            mask_d     = mask_q | s_sel_q;
            frame_done = (mask_d == 4'hF);
        end

        if (frame_done) begin
            mask_d = 4'h0;
            if (!valid_q || accept) begin
                word_d  = slot_d;
                err_d   = slot_err_d;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_seg_q    <= Blank;
            s_sel_q    <= 4'h0;
            cnt_q      <= 9'd0;
            slot_q     <= 16'h0000;
            slot_err_q <= 4'h0;
            mask_q     <= 4'h0;
            word_q     <= 16'h0000;
            err_q      <= 4'h0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            s_seg_q    <= seg;
            s_sel_q    <= dig_sel;
            cnt_q      <= cnt_d;
            slot_q     <= slot_d;
            slot_err_q <= slot_err_d;
            mask_q     <= mask_d;
            word_q     <= word_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            ovr_q      <= ovr_d;
        end
    end

    assign out_word  = word_q;
    assign out_err   = err_q;
    assign out_valid = valid_q;
    assign overrun   = ovr_q;

endmodule
